// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 multiply/divide unit with HI/LO result registers.
// Define MDU_DIV_EN to build the divide datapath. Without it, DIV/DIVU complete on
// the next edge with err=1 and leave hi/lo untouched.
//
// Handshake: a request is accepted on a rising edge of clk when start=1 and busy=0
// (FSM in IDLE or DONE). A request seen while busy=1 is dropped, never queued. done
// is a one-cycle pulse that marks the cycle in which hi/lo hold the new result.
// op, a and b are sampled only on the accepting edge.
module mul_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [5:0]  count;
  logic        is_div_q;
  logic        sign_a_q;
  logic        sign_b_q;
  logic [31:0] opnd_q;
  logic [31:0] work_hi;
  logic [31:0] work_lo;
  logic        accept;
  logic        last_iter;
  logic        in_signed;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] mul_sum;
  logic [31:0] it_hi;
  logic [31:0] it_lo;
  logic [63:0] prod;
  logic [31:0] commit_hi;
  logic [31:0] commit_lo;
`ifdef MDU_DIV_EN
  logic [31:0] a_q;
  logic        b_zero_q;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic        div_ge;
  logic [31:0] quo;
  logic [31:0] rem;
`endif

  assign accept    = (state != BUSY) && start;
  assign last_iter = (state == BUSY) && (count == 6'd31);
  assign in_signed = ~op[0];
  assign mag_a     = (in_signed && a[31]) ? (~a + 32'd1) : a;
  assign mag_b     = (in_signed && b[31]) ? (~b + 32'd1) : b;

  assign busy      = (state == BUSY);
  assign done      = (state == DONE);
  assign dbg_state = state;
`ifdef MDU_DIV_EN
  assign err       = 1'b0;
`else
  assign err       = (state == DONE) && is_div_q;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: accept from IDLE/DONE, run 32 iterations in BUSY, pulse DONE once.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
`ifdef MDU_DIV_EN
          state_next = BUSY;
`else
          state_next = op[1] ? DONE : BUSY;
`endif
        end else begin
          state_next = IDLE;
        end
      end
      BUSY:    if (count == 6'd31) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Iteration counter: cleared on accept, advances once per BUSY cycle.
  always_ff @(posedge clk) begin
    if (reset)              count <= 6'd0;
    else if (accept)        count <= 6'd0;
    else if (state == BUSY) count <= count + 6'd1;
  end

  // One radix-2 step on the working registers (shift-add or restoring subtract).
  always_comb begin
    mul_sum = {1'b0, work_hi} + {1'b0, (work_lo[0] ? opnd_q : 32'd0)};
    it_hi   = mul_sum[32:1];
    it_lo   = {mul_sum[0], work_lo[31:1]};
`ifdef MDU_DIV_EN
    div_shift = {work_hi, work_lo[31]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    if (is_div_q) begin
      it_hi = div_ge ? div_diff[31:0] : div_shift[31:0];
      it_lo = {work_lo[30:0], div_ge};
    end
`endif
  end

  // Operand capture on accept; working registers step every BUSY cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opnd_q   <= 32'd0;
      work_hi  <= 32'd0;
      work_lo  <= 32'd0;
`ifdef MDU_DIV_EN
      a_q      <= 32'd0;
      b_zero_q <= 1'b0;
`endif
    end else if (accept) begin
      is_div_q <= op[1];
      sign_a_q <= in_signed & a[31];
      sign_b_q <= in_signed & b[31];
      opnd_q   <= mag_b;
      work_hi  <= 32'd0;
      work_lo  <= mag_a;
`ifdef MDU_DIV_EN
      a_q      <= a;
      b_zero_q <= (b == 32'd0);
`endif
    end else if (state == BUSY) begin
      work_hi  <= it_hi;
      work_lo  <= it_lo;
    end
  end

  // Sign correction of the final step's magnitudes, applied as the result commits.
  always_comb begin
    prod = {it_hi, it_lo};
    if (sign_a_q ^ sign_b_q) prod = ~prod + 64'd1;
    commit_hi = prod[63:32];
    commit_lo = prod[31:0];
`ifdef MDU_DIV_EN
    quo = (sign_a_q ^ sign_b_q) ? (~it_lo + 32'd1) : it_lo;
    rem = sign_a_q ? (~it_hi + 32'd1) : it_hi;
    if (is_div_q) begin
      if (b_zero_q) begin
        commit_hi = a_q;
        commit_lo = 32'hFFFF_FFFF;
      end else begin
        commit_hi = rem;
        commit_lo = quo;
      end
    end
`endif
  end

  // HI/LO hold their value except on the edge that ends the last iteration.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (last_iter) begin
      hi <= commit_hi;
      lo <= commit_lo;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit (either MDU_DIV_EN setting).
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        err;
  logic [1:0]  dbg_state;

  logic [64:0] exp_q[$];
  logic [64:0] mon_e;
  logic [31:0] model_hi;
  logic [31:0] model_lo;
  logic [31:0] prev_hi;
  logic [31:0] prev_lo;
  int          n_cmp;
  int          n_err;

  mul_div_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference result {err, hi, lo}; prev is the HI/LO content before the operation.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [63:0] prev);
    logic signed [63:0] sx, sy, q, r;
    logic [63:0] p;
    model = {1'b0, prev};
    case (o)
      2'b00: begin
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        p = sx * sy;
        model = {1'b0, p};
      end
      2'b01: begin
        p = {32'd0, x} * {32'd0, y};
        model = {1'b0, p};
      end
      default: begin
`ifdef MDU_DIV_EN
        if (y == 32'd0) begin
          model = {1'b0, x, 32'hFFFF_FFFF};
        end else begin
          if (o == 2'b10) begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
          end else begin
            sx = {32'd0, x};
            sy = {32'd0, y};
          end
          q = sx / sy;
          r = sx % sy;
          model = {1'b0, r[31:0], q[31:0]};
        end
`else
        model = {1'b1, prev};
`endif
      end
    endcase
  endfunction

  function automatic int lat_of(input logic [1:0] o);
`ifdef MDU_DIV_EN
    lat_of = 33;
`else
    lat_of = o[1] ? 1 : 33;
`endif
  endfunction

  // Driver: present a request at a falling edge, return at the falling edge after accept.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [64:0] e;
    e = model(o, x, y, {model_hi, model_lo});
    prev_hi  = model_hi;
    prev_lo  = model_lo;
    model_hi = e[63:32];
    model_lo = e[31:0];
    exp_q.push_back(e);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count falling edges after accept until done; busy must be up and hi/lo held meanwhile.
  task automatic wait_done(input int exp_lat, input bit scramble);
    int k;
    k = 1;
    while (done !== 1'b1 && k < 200) begin
      check("busy", {63'd0, busy}, 64'd1);
      check("hold", {hi, lo}, {prev_hi, prev_lo});
      if (scramble) begin
        a  = $urandom;
        b  = $urandom;
        op = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
      k++;
    end
    check("latency", 64'(k), 64'(exp_lat));
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    issue(o, x, y);
    wait_done(lat_of(o), 1'b0);
    @(negedge clk);
  endtask

  // Scoreboard: every done pulse pops and compares one expected result.
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("hilo", {hi, lo}, mon_e[63:0]);
        check("err", {63'd0, err}, {63'd0, mon_e[64]});
      end
    end
  end

  initial begin
    int dones;
    n_cmp    = 0;
    n_err    = 0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    prev_hi  = 32'd0;
    prev_lo  = 32'd0;
    reset    = 1'b1;
    start    = 1'b0;
    op       = 2'b00;
    a        = 32'd0;
    b        = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state.
    check("rst_ctl", {60'd0, busy, done, err, 1'b0}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);

    // Full-width unsigned product and 33-edge latency.
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max", {model_hi, model_lo}, 64'hFFFF_FFFE_0000_0001);

    // Signed product, then back-to-back start while in DONE.
    issue(2'b00, 32'hFFFF_FFFD, 32'd5);
    wait_done(33, 1'b0);
    issue(2'b01, 32'd2, 32'd3);
    wait_done(33, 1'b0);
    @(negedge clk);

    // Divide cases (or the unsupported-op path when divide is not built in).
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op(2'b11, 32'd7, 32'd0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0);
    run_op(2'b11, 32'hFFFF_FFF0, 32'd3);

    // Inputs wiggling during BUSY must not disturb the latched operands.
    issue(2'b01, 32'd1000, 32'd1000);
    wait_done(33, 1'b1);
    @(negedge clk);
    check("scramble", {model_hi, model_lo}, 64'h0000_0000_000F_4240);

    // Random operations.
    for (int i = 0; i < 8; i++) begin
      logic [1:0] ro;
      ro = 2'($urandom_range(0, 3));
      run_op(ro, $urandom, (i == 3) ? 32'd0 : $urandom);
    end

    // Ignored start at busy cycle 5, reset at busy cycle 10 aborts with no done.
    issue(2'b01, 32'd10, 32'd10);
    for (int k = 1; k < 10; k++) begin
      start = (k == 5);
      op    = 2'b00;
      a     = 32'd3;
      b     = 32'd4;
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_before_rst", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_state", {62'd0, dbg_state}, 64'd0);
    exp_q.delete();
    model_hi = 32'd0;
    model_lo = 32'd0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    check("no_done_after_abort", 64'(dones), 64'd0);

    // Reset and start together: reset wins.
    reset = 1'b1;
    start = 1'b1;
    op    = 2'b01;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("rst_over_start", {62'd0, dbg_state}, 64'd0);

    // Operation after abort still works.
    run_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000);

    repeat (3) @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
